// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline forwarding/hazard logic:
// forward-select encodings, slot indexing and the EX slot control bundle.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    // Slot index into the per-stage pipes: 0 = EX, 1 = MEM, 2 = WB.
    localparam int STAGES   = 2;
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic use_rs;
        logic use_rt;
        logic we;
        logic load;
    } slot_ctl_t;

endpackage

// File: rtl/reg_match.sv
// One source-register versus one slot-destination compare; register 0
// never counts as a producer.
module reg_match
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              src_use,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wr,
    output logic              match
);

    assign match = src_use & wr & (rd != '0) & (src == rd);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects for EX and load-use / RAW stall for ID, driven from a
// private shadow of the EX, MEM and WB destination info.
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][ADDR_W-1:0] rd_pipe;
    logic [STAGES:SLOT_MEM]      we_pipe;
    slot_ctl_t                   ex_ctl;
    logic [ADDR_W-1:0]           ex_rs, ex_rt;
    logic [STAGES:0]             slot_wr;
    logic                        ex_load;

    logic [1:0][ADDR_W-1:0] id_src, ex_src;
    logic [1:0]             id_use, ex_use;
    logic [1:0][1:0]        id_hit;   // [src][EX, MEM]
    logic [1:0][1:0]        ex_hit;   // [src][MEM, WB]
    logic [1:0][1:0]        sel;

    assign slot_wr[SLOT_EX]  = vld_pipe[SLOT_EX]  & ex_ctl.we;
    assign slot_wr[SLOT_MEM] = vld_pipe[SLOT_MEM] & we_pipe[SLOT_MEM];
    assign slot_wr[SLOT_WB]  = vld_pipe[SLOT_WB]  & we_pipe[SLOT_WB];

    assign id_src = {id_rt, id_rs};
    assign id_use = {id_use_rt, id_use_rs};
    assign ex_src = {ex_rt, ex_rs};
    assign ex_use = {ex_ctl.use_rt, ex_ctl.use_rs};

    // ID sources look at EX/MEM for stalls; EX sources look at MEM/WB for forwarding.
    for (genvar s = 0; s < 2; s++) begin : g_src
        for (genvar k = 0; k < 2; k++) begin : g_slot
            reg_match #(.ADDR_W(ADDR_W)) u_id (
                .src_use (id_use[s]),
                .src     (id_src[s]),
                .rd      (rd_pipe[k]),
                .wr      (slot_wr[k]),
                .match   (id_hit[s][k])
            );
            reg_match #(.ADDR_W(ADDR_W)) u_ex (
                .src_use (ex_use[s]),
                .src     (ex_src[s]),
                .rd      (rd_pipe[k+1]),
                .wr      (slot_wr[k+1]),
                .match   (ex_hit[s][k])
            );
        end
    end

    always_comb begin
        stall = 1'b0;
        if (id_valid) begin
            if (FWD_EN)
                stall = (id_hit[0][0] | id_hit[1][0]) & ex_ctl.load;
            else
                stall = |id_hit;
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            sel[s] = FWD_RF;
            if (FWD_EN && vld_pipe[SLOT_EX]) begin
                if (ex_hit[s][0])
                    sel[s] = FWD_MEM;
                else if (ex_hit[s][1])
                    sel[s] = FWD_WB;
            end
        end
    end

    assign fwd_a    = sel[0];
    assign fwd_b    = sel[1];
    assign ex_valid = vld_pipe[SLOT_EX];
    assign ex_load  = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            rd_pipe   <= '0;
            we_pipe   <= '0;
            ex_ctl    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            stall_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], ex_load};
            rd_pipe  <= {rd_pipe[STAGES-1:0], id_rd};
            we_pipe  <= {we_pipe[SLOT_MEM], ex_ctl.we};
            // EX payload is don't-care on a bubble, so it loads unconditionally.
            ex_ctl   <= '{use_rs: id_use_rs, use_rt: id_use_rt, we: id_we, load: id_load};
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage MIPS pipeline; successor to the fixed 2-bit register-equality compare used by the forwarding logic.
- Keeps its own shadow copy of destination-register info for the EX, MEM and WB stages.
- Drives the ALU operand forward selects for the instruction in EX.
- Generates the load-use stall for the instruction in ID.
- Supports two modes: full forwarding, or stall-only when forwarding is disabled.

Parameters:
- ADDR_W, 5, register address width.
- FWD_EN, 1, 1 = forward from MEM/WB and stall only on load-use; 0 = no forwarding, stall on any RAW against EX or MEM.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  ADDR_W  ID source register A.
- id_rt  in  ADDR_W  ID source register B.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  ADDR_W  ID destination register.
- id_we  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- flush  in  1  branch resolved taken; kill the instruction leaving ID.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result.
- fwd_b  out  2  EX operand B select, same encoding.
- ex_valid  out  1  EX slot holds a real instruction.
- stall_cnt  out  CNT_W  cycles with stall asserted, saturating.

Behaviour:
- Reset (asynchronous, reset_n low): all slot valid bits 0, stall_cnt 0. Because every slot is invalid, stall=0, fwd_a=fwd_b=00 and ex_valid=0.
- Slot contents:
  - EX: {valid, rs, rt, use_rs, use_rt, rd, we, load}.
  - MEM: {valid, rd, we, load}.
  - WB: {valid, rd, we}.
- Every rising clk edge: WB<=MEM and MEM<=EX, unconditionally.
- EX loads the ID fields when id_valid & !stall & !flush. Otherwise EX valid<=0 (bubble) and the other EX fields are don't-care.
- Effective write of a slot = valid & we & (rd != 0). Register 0 is never a hazard or forward source.
- Source match for operand A = use_rs & (rs == slot.rd) & slot effective write. Operand B uses rt and use_rt the same way.
- Forwarding, combinational from the EX slot, when FWD_EN=1:
  - EX source matches MEM -> 10.
  - Else EX source matches WB -> 01.
  - Else 00.
  - MEM has priority over WB (youngest value wins).
  - ex_valid=0 -> 00.
  - Forwarding from MEM when MEM.load=1 cannot occur; the stall rule prevents it.
- When FWD_EN=0: fwd_a and fwd_b are tied to 00. The register file is write-first, so WB needs no handling.
- Stall, combinational, qualified by id_valid:
  - FWD_EN=1: an ID source matches EX while EX.load=1.
  - FWD_EN=0: an ID source matches EX, or matches MEM.
- Stall duration:
  - Load-use stalls exactly 1 cycle; the bubble moves the load to MEM.
  - FWD_EN=0 stalls up to 2 cycles.
- flush together with stall: flush wins. EX gets a bubble, and stall is still output; IF/ID is being flushed, so the hold is harmless.
- Back-to-back matches: the same register matching both MEM and WB selects MEM.
- stall_cnt increments on each clk edge with stall=1 and saturates at all-ones; no wrap.
- reset_n asserting mid-stall clears all slots immediately; stall drops in the same cycle, asynchronously.

Decomposition:
- Shared package mips_pkg holds:
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - A packed slot typedef.
  - The ADDR_W default.
- One sub-module: reg_match, parametrised on ADDR_W. Inputs: use, src, slot rd, slot valid&we. Output: match, with the rd!=0 check inside. It is the generalisation of the 2-bit equality compare. Instantiate it 2 sources x 3 slots.

Test Plan:
- Reset then idle: reset_n=0 at t=3 (mid-cycle), release at t=20 -> stall=0, fwd_a=fwd_b=00, ex_valid=0, stall_cnt=0 immediately at assertion.
- ALU RAW, FWD_EN=1:
  - Issue add rd=8 then sub rs=8, rt=9 -> next cycle fwd_a=10, fwd_b=00, stall=0.
  - Insert one independent instruction between them -> fwd_a=01.
- Load-use, FWD_EN=1: lw rd=5 followed by add rt=5 -> stall=1 for exactly one cycle, ex_valid=0 the next cycle, then fwd_b=01 for the add; stall_cnt=1.
- Register zero and priority:
  - Writes to rd=0 followed by a reader of rs=0 -> fwd_a=00, no stall.
  - Writes to rd=3 in both MEM and WB -> fwd_a=10.
- FWD_EN=0 build: add rd=4 then or rs=4 -> stall for 2 cycles, fwd always 00, stall_cnt=2.
- Flush with stall: lw rd=6 in EX, ID reads rs=6, flush=1 in the same cycle -> EX bubble; no forward next cycle; stall_cnt saturates at 16'hFFFF under a forced long stall.
